// File: rtl/digit_feeder_163_d8_if.sv
// Operand/digit bus between the digit feeder and its host/array side.
interface digit_feeder_163_d8_if #(
  parameter int M = 163,
  parameter int D = 8
);
  logic         start;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
  logic         en;
  logic [M-1:0] a_out;
  logic [D-1:0] b_digit;
  logic         digit_valid;
  logic [4:0]   digit_idx;
  logic         clr_acc;
  logic         last_digit;
  logic         busy;
  logic         done;

  modport master (
    output start, a_in, b_in, en,
    input  a_out, b_digit, digit_valid, digit_idx, clr_acc, last_digit, busy, done
  );

  modport slave (
    input  start, a_in, b_in, en,
    output a_out, b_digit, digit_valid, digit_idx, clr_acc, last_digit, busy, done
  );
endinterface

// File: rtl/digit_feeder_163_d8.sv
// Operand sequencer for the GF(2^163) digit-serial multiplier: holds A, feeds B
// MSD-first one digit per enabled cycle, then waits out the array latency.
module digit_feeder_163_d8 #(
  parameter int M        = 163,
  parameter int D        = 8,
  parameter int NDIG     = (M + D - 1) / D,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  digit_feeder_163_d8_if.slave bus
);
  localparam int W  = NDIG * D;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   sreg, sreg_n;
  logic [4:0]     idx, idx_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [M-1:0]   a_q, a_n;
  logic           valid, clr, last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
      cnt   <= '0;
      a_q   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    idx_n   = idx;
    cnt_n   = cnt;
    a_n     = a_q;
    valid   = 1'b0;
    clr     = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_n     = bus.a_in;
          sreg_n  = W'(bus.b_in);
          idx_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          valid = 1'b1;
          clr   = (idx == 5'd0);
          last  = (idx == 5'(NDIG - 1));
          if (idx == 5'(NDIG - 1)) begin
            if (PIPE_LAT == 0) begin
              state_n = DONE;
            end else begin
              state_n = FLUSH;
              cnt_n   = CW'(PIPE_LAT - 1);
            end
          end else begin
            sreg_n = sreg << D;
            idx_n  = idx + 5'd1;
          end
        end
      end
      FLUSH: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The top digit is always the one on offer; the register is zero after reset.
  assign bus.b_digit     = sreg[W-1 -: D];
  assign bus.a_out       = a_q;
  assign bus.digit_idx   = idx;
  assign bus.digit_valid = valid;
  assign bus.clr_acc     = clr;
  assign bus.last_digit  = last;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_digit_feeder_163_d8.sv
// Directed-vector bench for digit_feeder_163_d8 with immediate-assertion checks.
module tb_digit_feeder_163_d8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  digit_feeder_163_d8_if #(.M(163), .D(8)) bus ();

  digit_feeder_163_d8 #(.M(163), .D(8), .NDIG(21), .PIPE_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full operation. Expected digits: d0 for digit 0, dl for digit 20, dm otherwise.
  task automatic run_op(input logic [162:0] a, input logic [162:0] b,
                        input logic [7:0] d0, input logic [7:0] dm, input logic [7:0] dl,
                        input int stall_at, input bit pulse5, input bit hold);
    int t0;
    logic [7:0] exp_d;
    t0 = cyc;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.en    = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    for (int k = 0; k < 21; k++) begin
      exp_d = (k == 0) ? d0 : ((k == 20) ? dl : dm);
      if (k == stall_at) begin
        bus.en = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
          chk("stall_idx", bus.digit_idx, k);
          chk("stall_digit", bus.b_digit, exp_d);
          chk("stall_valid", bus.digit_valid, 1'b0);
          chk("stall_clr", bus.clr_acc, 1'b0);
          chk("stall_last", bus.last_digit, 1'b0);
          step();
        end
        bus.en = 1'b1;
        #1;
      end
      chk("digit", bus.b_digit, exp_d);
      chk("idx", bus.digit_idx, k);
      chk("valid", bus.digit_valid, 1'b1);
      chk("clr_acc", bus.clr_acc, (k == 0));
      chk("last_digit", bus.last_digit, (k == 20));
      chk("a_out_held", bus.a_out, a);
      chk("busy_shift", bus.busy, 1'b1);
      chk("done_early", bus.done, 1'b0);
      if (pulse5 && k == 5) begin
        bus.start = 1'b1;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
      end
      step();
      if (pulse5 && k == 5) begin
        bus.start = 1'b0;
        bus.a_in  = a;
        bus.b_in  = b;
      end
    end
    chk("flush_valid", bus.digit_valid, 1'b0);
    chk("flush_busy", bus.busy, 1'b1);
    chk("flush_done0", bus.done, 1'b0);
    step();
    chk("flush_done1", bus.done, 1'b0);
    step();
    chk("done", bus.done, 1'b1);
    chk("latency", cyc - t0, (stall_at >= 0) ? 27 : 24);
    chk("a_out_done", bus.a_out, a);
    step();
    chk("done_pulse_end", bus.done, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("a_out_idle", bus.a_out, a);
  endtask

  initial begin
    logic [162:0] ones;
    logic [162:0] a4;
    logic [162:0] b4;
    ones = '1;
    a4   = 163'h1_2345_6789;
    b4   = {3'b011, 8'hA5, 152'h0};
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.en    = 1'b1;
    step();
    step();
    chk("rst_a_out", bus.a_out, 0);
    chk("rst_digit", bus.b_digit, 0);
    chk("rst_idx", bus.digit_idx, 0);
    chk("rst_valid", bus.digit_valid, 1'b0);
    chk("rst_clr", bus.clr_acc, 1'b0);
    chk("rst_last", bus.last_digit, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    step();

    run_op(163'h1, 163'h1, 8'h00, 8'h00, 8'h01, -1, 1'b0, 1'b0);
    run_op(163'h2, {3'b101, 160'h0}, 8'h05, 8'h00, 8'h00, -1, 1'b0, 1'b0);
    run_op(163'h3, ones, 8'h07, 8'hFF, 8'hFF, -1, 1'b0, 1'b0);
    run_op(163'h4, 163'h1, 8'h00, 8'h00, 8'h01, 10, 1'b0, 1'b0);
    run_op(163'h5, {3'b101, 160'h0}, 8'h05, 8'h00, 8'h00, -1, 1'b1, 1'b0);

    // Start held high: back-to-back acceptance in the IDLE cycle after done.
    run_op(163'h5A, 163'h1, 8'h00, 8'h00, 8'h01, -1, 1'b0, 1'b1);
    bus.a_in = a4;
    bus.b_in = b4;
    step();
    chk("b2b_busy", bus.busy, 1'b1);
    chk("b2b_idx", bus.digit_idx, 0);
    chk("b2b_a_out", bus.a_out, a4);
    chk("b2b_digit0", bus.b_digit, 8'h03);
    chk("b2b_clr", bus.clr_acc, 1'b1);
    bus.start = 1'b0;
    step();
    chk("b2b_digit1", bus.b_digit, 8'hA5);
    repeat (11) step();
    chk("pre_abort_idx", bus.digit_idx, 12);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_valid", bus.digit_valid, 1'b0);
    chk("abort_digit", bus.b_digit, 0);
    chk("abort_idx", bus.digit_idx, 0);
    chk("abort_a_out", bus.a_out, 0);
    chk("abort_done", bus.done, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("abort_no_done", bus.done, 1'b0);
    end

    run_op(163'h3, {3'b010, {20{8'h3C}}}, 8'h02, 8'h3C, 8'h3C, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
